// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an external 8-bit up/down loadable counter.
// Optional SWEEP_PINGPONG_EN: reverse direction between passes instead of reloading.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; outputs parked, pass_cnt holds last result
// S_LOAD | one cycle, counter loads start_q, direction fixed
// S_RUN  | counter enabled until cnt_out reaches end_q
// S_DONE | one cycle, done pulse, then back to idle
module counter_sweep_ctrl #(
    parameter int WIDTH  = 8,
    parameter int LOOP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cfg_start,
    input  logic [WIDTH-1:0]  cfg_end,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic [WIDTH-1:0]  cnt_out,
    output logic [WIDTH-1:0]  cnt_data,
    output logic              cnt_load,
    output logic              cnt_enable,
    output logic              cnt_up_down,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LOOP_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  start_q, start_d;
    logic [WIDTH-1:0]  end_q, end_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              load_q, load_d;
    logic              up_q, up_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              busy_q, busy_d;
    logic              at_end;

    assign at_end = (cnt_out == end_q);

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        loops_d   = loops_q;
        pass_d    = pass_q;
        data_d    = data_q;
        load_d    = 1'b0;
        up_d      = up_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        busy_d    = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        start_d = cfg_start;
                        end_d   = cfg_end;
                        loops_d = cfg_loops;
                        pass_d  = '0;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (at_end) begin
                        if (pass_q != '1) begin
                            pass_d = pass_q + LOOP_W'(1);
                        end
                        if (loops_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            loops_d = loops_q - LOOP_W'(1);
`ifdef SWEEP_PINGPONG_EN
                            // Counter already sits on end_q, so just turn around.
                            start_d = end_q;
                            end_d   = start_q;
                            up_d    = ~up_q;
`else
                            state_d = S_LOAD;
`endif
                        end
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_LOAD) begin
            load_d = 1'b1;
            data_d = start_d;
            up_d   = (end_d >= start_d);
        end
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            loops_q   <= '0;
            pass_q    <= '0;
            data_q    <= '0;
            load_q    <= 1'b0;
            up_q      <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            loops_q   <= loops_d;
            pass_q    <= pass_d;
            data_q    <= data_d;
            load_q    <= load_d;
            up_q      <= up_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    // Enable is combinational so the counter stops on end_q without overshoot.
    assign cnt_enable  = (state_q == S_RUN) && !at_end && !abort;
    assign cnt_load    = load_q && !abort;
    assign cnt_data    = data_q;
    assign cnt_up_down = up_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign pass_cnt    = pass_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural counter plus a trace model of
// expected cnt_out per cycle, built from start/end/loop arithmetic.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_start = 8'h00;
    logic [7:0] cfg_end = 8'h00;
    logic [7:0] cfg_loops = 8'h00;
    logic [7:0] cnt_out = 8'h00;
    logic [7:0] cnt_data;
    logic       cnt_load;
    logic       cnt_enable;
    logic       cnt_up_down;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    counter_sweep_ctrl #(.WIDTH(8), .LOOP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_loops(cfg_loops),
        .cnt_out(cnt_out), .cnt_data(cnt_data), .cnt_load(cnt_load),
        .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down), .busy(busy),
        .done(done), .aborted(aborted), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // The counter being sequenced: load wins over enable.
    always @(posedge clk) begin
        if (cnt_load) cnt_out <= cnt_data;
        else if (cnt_enable) cnt_out <= cnt_up_down ? cnt_out + 8'd1 : cnt_out - 8'd1;
    end

    // Expected cnt_out after each clock edge following the start edge.
    function automatic void build_trace(input logic [7:0] s, input logic [7:0] e, input int loops);
        logic [7:0] a, b, cur, t;
        bit pp;
`ifdef SWEEP_PINGPONG_EN
        pp = 1'b1;
`else
        pp = 1'b0;
`endif
        exp_q.delete();
        a = s; b = e; cur = s;
        for (int p = 0; p <= loops; p++) begin
            if (p == 0 || !pp) begin
                cur = a;
                exp_q.push_back(cur);
            end
            while (cur != b) begin
                if (b > cur) cur = cur + 8'd1;
                else cur = cur - 8'd1;
                exp_q.push_back(cur);
            end
            exp_q.push_back(cur);
            if (pp) begin t = a; a = b; b = t; end
        end
    endfunction

    task automatic check_reset_values(input string tag);
        checks++;
        if (cnt_load !== 1'b0 || cnt_enable !== 1'b0 || cnt_up_down !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            pass_cnt !== 8'h00 || cnt_data !== 8'h00) begin
            errors++;
            $display("FAIL %s: load=%b en=%b ud=%b busy=%b done=%b abt=%b pass=%0d data=%h, required 0 0 1 0 0 0 0 00",
                     tag, cnt_load, cnt_enable, cnt_up_down, busy, done, aborted, pass_cnt, cnt_data);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_values("reset_state");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_cmd(input logic [7:0] s, input logic [7:0] e, input int loops, input bit poke);
        int n;
        int exp_pass;
        build_trace(s, e, loops);
        n = exp_q.size();
        exp_pass = (loops + 1 > 255) ? 255 : loops + 1;
        @(negedge clk);
        cfg_start = s; cfg_end = e; cfg_loops = loops[7:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_start = 8'($urandom); cfg_end = 8'($urandom); cfg_loops = 8'($urandom);
        checks++;
        if (cnt_load !== 1'b1 || cnt_data !== s) begin
            errors++;
            $display("FAIL load: load=%b data=%h, required 1 %h", cnt_load, cnt_data, s);
        end
        checks++;
        if (cnt_up_down !== (e >= s)) begin
            errors++;
            $display("FAIL dir: up_down=%b, required %b", cnt_up_down, (e >= s));
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: busy=%b, required 1", busy);
        end
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (poke && k == 3) begin
                start = 1'b1;
                cfg_start = 8'($urandom); cfg_end = 8'($urandom); cfg_loops = 8'($urandom);
            end
            if (poke && k == 4) start = 1'b0;
            checks++;
            if (cnt_out !== exp_q[k-1]) begin
                errors++;
                $display("FAIL trace s=%h e=%h cyc=%0d: cnt_out=%h, required %h", s, e, k, cnt_out, exp_q[k-1]);
            end
            checks++;
            if (done !== (k == n)) begin
                errors++;
                $display("FAIL done_timing s=%h e=%h cyc=%0d: done=%b, required %b", s, e, k, done, (k == n));
            end
        end
        start = 1'b0;
        checks++;
        if (pass_cnt !== exp_pass[7:0]) begin
            errors++;
            $display("FAIL pass_cnt: %0d, required %0d", pass_cnt, exp_pass);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pass_cnt !== exp_pass[7:0] || cnt_out !== exp_q[n-1]) begin
            errors++;
            $display("FAIL hold_after_done: pass=%0d cnt=%h, required %0d %h", pass_cnt, cnt_out, exp_pass, exp_q[n-1]);
        end
    endtask

    task automatic test_directed();
        run_cmd(8'h00, 8'h0F, 0, 1'b0);
        run_cmd(8'h0F, 8'h00, 0, 1'b0);
        run_cmd(8'h03, 8'h05, 2, 1'b0);
        run_cmd(8'h20, 8'h20, 0, 1'b0);
        run_cmd(8'hFE, 8'hFF, 1, 1'b0);
    endtask

    task automatic test_back_to_back_start();
        run_cmd(8'h10, 8'h18, 1, 1'b1);
        run_cmd(8'h90, 8'h88, 0, 1'b1);
    endtask

    task automatic test_saturation();
        run_cmd(8'h55, 8'h55, 255, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int s, d, ei, lp;
            s  = int'($urandom_range(0, 255));
            d  = int'($urandom_range(0, 12));
            ei = ($urandom_range(0, 1) == 1) ? s + d : s - d;
            if (ei < 0) ei = 0;
            if (ei > 255) ei = 255;
            lp = int'($urandom_range(0, 3));
            run_cmd(s[7:0], ei[7:0], lp, (d >= 3) && ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        @(negedge clk);
        cfg_start = 8'h00; cfg_end = 8'h0F; cfg_loops = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cnt_out == 8'h07) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach: cnt_out=%h, required 07 within 40 cycles", cnt_out);
        end else begin
            checks++;
            if (cnt_enable !== 1'b1) begin
                errors++;
                $display("FAIL abort_pre_en: cnt_enable=%b, required 1", cnt_enable);
            end
            abort = 1'b1;
            #1;
            checks++;
            if (cnt_enable !== 1'b0) begin
                errors++;
                $display("FAIL abort_mask: cnt_enable=%b, required 0", cnt_enable);
            end
            @(posedge clk); #1;
            abort = 1'b0;
            checks++;
            if (aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cnt_out !== 8'h07) begin
                errors++;
                $display("FAIL abort_pulse: aborted=%b done=%b busy=%b cnt=%h, required 1 0 0 07",
                         aborted, done, busy, cnt_out);
            end
            @(posedge clk); #1;
            checks++;
            if (aborted !== 1'b0 || done !== 1'b0 || cnt_out !== 8'h07) begin
                errors++;
                $display("FAIL abort_after: aborted=%b done=%b cnt=%h, required 0 0 07", aborted, done, cnt_out);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        cfg_start = 8'h30; cfg_end = 8'h40; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b0 || cnt_load !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b aborted=%b load=%b, required 0 0 0", busy, aborted, cnt_load);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        cfg_start = 8'h40; cfg_end = 8'h80; cfg_loops = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("reset_mid_run");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cnt_enable !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b en=%b, required 0 0", busy, cnt_enable);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_start_abort_idle();
        test_back_to_back_start();
        test_saturation();
        test_random();
        test_reset_mid_run();
        run_cmd(8'h0F, 8'h00, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the 8-bit up/down loadable counter. It takes a sweep command (start value, end value, repeat count), drives the counter's data/load/enable/up_down pins, and watches the counter output to stop exactly on the end value. It sits between a host or config register bank and one counter instance, with a start/busy/done handshake toward the host.

Parameters:
WIDTH, 8, counter data width
LOOP_W, 8, width of repeat count and pass counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  command request, sampled only in IDLE
abort  input  1  cancel current sweep
cfg_start  input  WIDTH  first counter value
cfg_end  input  WIDTH  terminal counter value
cfg_loops  input  LOOP_W  extra passes; total passes = cfg_loops+1
cnt_out  input  WIDTH  counter output feedback
cnt_data  output  WIDTH  counter load value
cnt_load  output  1  counter synchronous load
cnt_enable  output  1  counter count enable
cnt_up_down  output  1  1=up, 0=down
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on abort
pass_cnt  output  LOOP_W  completed passes of the current/last command

Behaviour:
- Counter contract: load has priority over enable; cnt_out updates on the rising clk edge.
- Reset (reset=0, async): state IDLE, cnt_data=0, cnt_load=0, cnt_enable=0, cnt_up_down=1, busy=0, done=0, aborted=0, pass_cnt=0. Latched config is cleared to 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: when start=1 and abort=0, latch cfg_start/cfg_end/cfg_loops, clear pass_cnt, go to LOAD. When start=1 and abort=1 together, stay in IDLE with no pulse.
- LOAD (1 cycle): cnt_load=1, cnt_data=start_q, cnt_enable=0, cnt_up_down=(end_q>=start_q). Next state is RUN.
- RUN: cnt_enable=(cnt_out!=end_q). This is combinational so the counter never overshoots. cnt_up_down is held.
- RUN, on cnt_out==end_q: pass_cnt increments. If passes remain, go to LOAD; otherwise go to DONE.
- start_q==end_q: zero enable cycles per pass; each pass is LOAD then one RUN cycle.
- Latency, start sampled at edge 0: load at edge 1, first enable edge 2. For a single pass, done asserts |end−start|+2 cycles after the start edge.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- abort=1 in LOAD/RUN/DONE: next state is IDLE and aborted pulses for one cycle. cnt_enable and cnt_load drop in the abort cycle (abort masks them combinationally). done is not pulsed. The counter keeps its current value.
- start while busy is ignored. Config inputs are don't-care outside the IDLE start cycle.
- pass_cnt saturates at 2^LOOP_W−1 and holds its value after DONE until the next accepted start.
- Outputs other than cnt_enable and the abort mask are registered.

Optional Feature:
Macro SWEEP_PINGPONG_EN.
- Defined: when a pass ends with passes remaining, swap start_q/end_q, invert cnt_up_down and go directly RUN→RUN with no LOAD cycle. The counter ping-pongs between the two values. The first pass still uses LOAD.
- Undefined: every pass reloads start_q through LOAD, giving a sawtooth.

Test Plan:
- Reset, start=1 with cfg_start=0x00, cfg_end=0x0F, cfg_loops=0 → cnt_load 1 cycle with data 0x00; cnt_out 0x00..0x0F; done pulses 17 cycles after the start edge; pass_cnt=1; cnt_enable=0 at 0x0F.
- cfg_start=0x0F, cfg_end=0x00, cfg_loops=0 → cnt_up_down=0; cnt_out 0x0F down to 0x00 with no underflow to 0xFF; done pulses.
- cfg_start=0x03, cfg_end=0x05, cfg_loops=2 → without macro, sequence 3,4,5,3,4,5,3,4,5 with pass_cnt=3 at done; with SWEEP_PINGPONG_EN, sequence 3,4,5,4,3,4,5.
- cfg_start=cfg_end=0x20, cfg_loops=0 → no enable cycles; done 2 cycles after start; cnt_out=0x20.
- abort at cnt_out=0x07 during a 0x00→0x0F sweep → cnt_enable low in the same cycle; aborted pulse; no done; cnt_out stays 0x07; busy drops next cycle.
- Assert reset mid-RUN → all outputs return to reset values immediately (async); start asserted during a sweep has no effect on the running sweep.
